memory_fifo_ctrl: RTL and testbench

//  Upstream controller for the 16x8 latch memory: turns it into a 16-entry FIFO.

---
 rtl/memory_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_memory_fifo_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_fifo_ctrl.sv
// 16-entry FIFO controller wrapped around an external latch memory with a fixed read latency.
// Pushes become registered write strobes; a small read FSM fetches the head entry and holds it on the pop port.
module memory_fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_activate,
  output logic [ADDR_W-1:0] mem_addrin,
  output logic [ADDR_W-1:0] mem_addrout,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  input  logic              mem_error,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [2:0]        LAT_C   = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_pend;
  logic [2:0]        lat;
  logic [ADDR_W:0]   pend_ext;
  logic              push_acc, pop_hs, rd_start, capture;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign push_ready = !full;
  assign pop_valid  = (state == HOLD);
  assign push_acc   = push_valid && push_ready;
  assign pop_hs     = (state == HOLD) && pop_ready;
  assign pend_ext   = {{ADDR_W{1'b0}}, wr_pend};

  // An entry whose write strobe is still on the bus is not yet readable.
  always_comb begin
    state_nxt = state;
    rd_start  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (count > pend_ext) begin
          state_nxt = WAIT;
          rd_start  = 1'b1;
        end
      end
      WAIT: begin
        if (lat == '0) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end
      end
      HOLD: begin
        if (pop_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_pend      <= 1'b0;
      count        <= '0;
      lat          <= '0;
      err          <= 1'b0;
      mem_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_activate <= 1'b0;
      mem_addrin   <= '0;
      mem_addrout  <= '0;
      mem_datain   <= '0;
      pop_data     <= '0;
    end else begin
      state        <= state_nxt;
      mem_write    <= push_acc;
      wr_pend      <= push_acc;
      mem_addrin   <= push_acc ? wr_ptr : '0;
      mem_datain   <= push_acc ? push_data : '0;
      mem_read     <= rd_start;
      mem_addrout  <= rd_start ? rd_ptr : '0;
      mem_activate <= push_acc || rd_start;
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_hs)   rd_ptr <= rd_ptr + PTR_ONE;
      if (push_acc && !pop_hs)      count <= count + CNT_ONE;
      else if (!push_acc && pop_hs) count <= count - CNT_ONE;
      // lat counts down the memory latency starting in the cycle mem_read is high.
      if (rd_start)                          lat <= LAT_C;
      else if (state == WAIT && lat != '0)   lat <= lat - 3'd1;
      if (capture) begin
        pop_data <= mem_dataout;
        err      <= err | mem_error;
      end
    end
  end

endmodule

// File: tb/tb_memory_fifo_ctrl.sv
// Bench for memory_fifo_ctrl: latency memory model, queue-based reference, vector table and directed/random sequences.
module tb_memory_fifo_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              push_valid, push_ready, pop_valid, pop_ready;
  logic [DATA_W-1:0] push_data, pop_data, mem_datain, mem_dataout;
  logic              mem_write, mem_read, mem_activate, mem_error;
  logic [ADDR_W-1:0] mem_addrin, mem_addrout;
  logic              full, empty, err;
  logic [ADDR_W:0]   count;

  always #5 clk = ~clk;

  memory_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_activate(mem_activate),
    .mem_addrin(mem_addrin), .mem_addrout(mem_addrout), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .mem_error(mem_error),
    .full(full), .empty(empty), .count(count), .err(err)
  );

  // Memory: data appears RD_LAT cycles after the mem_read cycle; junk before that.
  logic [7:0] mem [16];
  logic [7:0] rd_val;
  int         rd_wait;

  always_ff @(posedge clk) begin
    if (mem_write) mem[mem_addrin] <= mem_datain;
    if (reset) begin
      rd_wait <= 0;
    end else if (mem_read) begin
      rd_val <= mem[mem_addrout];
      if (RD_LAT == 1) mem_dataout <= mem[mem_addrout];
      else begin
        mem_dataout <= 8'($urandom);
        rd_wait     <= RD_LAT - 1;
      end
    end else if (rd_wait > 0) begin
      rd_wait     <= rd_wait - 1;
      mem_dataout <= (rd_wait == 1) ? rd_val : 8'($urandom);
    end
  end

  int         total = 0;
  int         bad = 0;
  logic [7:0] q[$];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic       exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference queue, then check outputs after the edge.
  task automatic cycle(input logic pv, input logic [7:0] pd, input logic pr);
    logic       acc, hs, was_pv;
    logic [7:0] held_pd;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    was_pv  = pop_valid;
    held_pd = pop_data;
    acc = pv && (q.size() < DEPTH);
    hs  = pop_valid && pr;
    if (hs) begin
      chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        chk("pop_data", 32'(pop_data), 32'(q[0]));
        void'(q.pop_front());
      end
    end
    if (acc) q.push_back(pd);
    @(posedge clk);
    @(negedge clk);
    chk("count", 32'(count), q.size());
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("push_ready", 32'(push_ready), 32'(q.size() < DEPTH));
    chk("mem_write", 32'(mem_write), 32'(acc));
    if (mem_read) begin
      chk("addrout", 32'(mem_addrout), rd_cnt % DEPTH);
      chk("read_written_slot", 32'(rd_cnt < wr_cnt), 32'd1);
      rd_cnt++;
    end
    if (acc) begin
      chk("addrin", 32'(mem_addrin), wr_cnt % DEPTH);
      chk("datain", 32'(mem_datain), 32'(pd));
      wr_cnt++;
    end
    chk("err", 32'(err), 32'(exp_err));
    if (pop_valid) chk("pv_nonempty", 32'(q.size() != 0), 32'd1);
    if (was_pv && !hs) begin
      chk("pv_hold", 32'(pop_valid), 32'd1);
      chk("pd_hold", 32'(pop_data), 32'(held_pd));
    end
  endtask

  task automatic do_reset(input int edges);
    reset = 1'b1; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0; mem_error = 1'b0;
    repeat (edges) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete(); wr_cnt = 0; rd_cnt = 0; exp_err = 1'b0;
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_strobes", 32'({mem_write, mem_read, mem_activate}), 32'd0);
    chk("rst_mem_bus", 32'({mem_addrin, mem_addrout, mem_datain}), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin cycle(1'b0, 8'h00, 1'b1); n++; end
    cycle(1'b0, 8'h00, 1'b0);
    chk("drain_count", 32'(count), 32'd0);
  endtask

  task automatic wait_read();
    int n = 0;
    while (!mem_read && n < 30) begin cycle(1'b0, 8'h00, 1'b0); n++; end
    chk("read_issued", 32'(mem_read), 32'd1);
  endtask

  typedef struct {
    logic pv; logic [7:0] pd; logic pr;
    logic [4:0] e_cnt; logic e_wr; logic [3:0] e_ain; logic [7:0] e_din;
    logic e_rd; logic [3:0] e_aout; logic e_pv; logic [7:0] e_pd;
  } vec_t;

  function automatic vec_t v(input logic pv, input logic [7:0] pd, input logic pr, input logic [4:0] c,
                             input logic w, input logic [3:0] ai, input logic [7:0] di,
                             input logic r, input logic [3:0] ao, input logic p, input logic [7:0] opd);
    vec_t t;
    t.pv = pv; t.pd = pd; t.pr = pr; t.e_cnt = c; t.e_wr = w; t.e_ain = ai; t.e_din = di;
    t.e_rd = r; t.e_aout = ao; t.e_pv = p; t.e_pd = opd;
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[20];
    int   n, got;
    logic wrap_w, wrap_r;
    logic [3:0] last_ain, last_aout, exp_wa, exp_ra;

    tbl[0]  = v(1'b1, 8'hA5, 1'b0, 5'd1, 1'b1, 4'd0, 8'hA5, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[1]  = v(1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[2]  = v(1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b0, 8'h00);
    tbl[3]  = v(1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[4]  = v(1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[5]  = v(1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 8'hA5);
    tbl[6]  = v(1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[7]  = v(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[8]  = v(1'b1, 8'h3C, 1'b0, 5'd1, 1'b1, 4'd1, 8'h3C, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[9]  = v(1'b1, 8'h5A, 1'b0, 5'd2, 1'b1, 4'd2, 8'h5A, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[10] = v(1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 1'b0, 8'h00);
    tbl[11] = v(1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[12] = v(1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[13] = v(1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h3C);
    tbl[14] = v(1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[15] = v(1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b0, 8'h00);
    tbl[16] = v(1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[17] = v(1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    tbl[18] = v(1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h5A);
    tbl[19] = v(1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);

    do_reset(2);

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].pv, tbl[i].pd, tbl[i].pr);
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("t%0d_mem_write", i), 32'(mem_write), 32'(tbl[i].e_wr));
      chk($sformatf("t%0d_mem_read", i), 32'(mem_read), 32'(tbl[i].e_rd));
      chk($sformatf("t%0d_mem_activate", i), 32'(mem_activate), 32'(tbl[i].e_wr | tbl[i].e_rd));
      chk($sformatf("t%0d_pop_valid", i), 32'(pop_valid), 32'(tbl[i].e_pv));
      if (tbl[i].e_wr) begin
        chk($sformatf("t%0d_addrin", i), 32'(mem_addrin), 32'(tbl[i].e_ain));
        chk($sformatf("t%0d_datain", i), 32'(mem_datain), 32'(tbl[i].e_din));
      end
      if (tbl[i].e_rd) chk($sformatf("t%0d_addrout", i), 32'(mem_addrout), 32'(tbl[i].e_aout));
      if (tbl[i].e_pv) chk($sformatf("t%0d_pop_data", i), 32'(pop_data), 32'(tbl[i].e_pd));
    end

    // Fill to 16 with the consumer stalled, try a 17th, then drain in order.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_push_ready", 32'(push_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd16);
    cycle(1'b1, 8'hEE, 1'b0);
    chk("no_17th_write", 32'(mem_write), 32'd0);
    chk("no_17th_count", 32'(count), 32'd16);
    got = 0; n = 0;
    while (got < 16 && n < 300) begin
      if (pop_valid) begin
        chk("fill_order", 32'(pop_data), got);
        got++;
      end
      cycle(1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("fill_popped", got, 32'd16);
    cycle(1'b0, 8'h00, 1'b0);
    chk("fill_empty", 32'(empty), 32'd1);

    // Interleaved pushes and pops across the pointer wrap.
    wrap_w = 1'b0; wrap_r = 1'b0; last_ain = '0; last_aout = '0;
    for (int i = 0; i < 60; i++) begin
      cycle((i % 3) == 0, 8'h40 + 8'(i), 1'b1);
      if (mem_write) begin
        if (last_ain == 4'd15 && mem_addrin == 4'd0) wrap_w = 1'b1;
        last_ain = mem_addrin;
      end
      if (mem_read) begin
        if (last_aout == 4'd15 && mem_addrout == 4'd0) wrap_r = 1'b1;
        last_aout = mem_addrout;
      end
    end
    n = 0;
    while (q.size() != 0 && n < 300) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (mem_read) begin
        if (last_aout == 4'd15 && mem_addrout == 4'd0) wrap_r = 1'b1;
        last_aout = mem_addrout;
      end
      n++;
    end
    chk("wrap_addrin", 32'(wrap_w), 32'd1);
    chk("wrap_addrout", 32'(wrap_r), 32'd1);
    drain();

    // Push and pop handshake together at count 5.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    n = 0;
    while (!pop_valid && n < 30) begin cycle(1'b0, 8'h00, 1'b0); n++; end
    chk("simul_pv", 32'(pop_valid), 32'd1);
    exp_wa = 4'(wr_cnt % DEPTH);
    exp_ra = 4'(rd_cnt % DEPTH);
    cycle(1'b1, 8'h77, 1'b1);
    chk("simul_count", 32'(count), 32'd5);
    chk("simul_addrin", 32'(mem_addrin), 32'(exp_wa));
    wait_read();
    chk("simul_next_read", 32'(mem_addrout), 32'(exp_ra));
    drain();

    // mem_error outside the capture cycle is ignored; inside it sets the sticky flag.
    cycle(1'b1, 8'h99, 1'b0);
    wait_read();
    mem_error = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    mem_error = 1'b0;
    repeat (RD_LAT - 1) cycle(1'b0, 8'h00, 1'b0);
    chk("err_noncapture", 32'(err), 32'd0);
    mem_error = 1'b1;
    exp_err = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    mem_error = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    chk("err_pop_valid", 32'(pop_valid), 32'd1);
    chk("err_byte_delivered", 32'(pop_data), 32'h99);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    drain();
    chk("err_sticky", 32'(err), 32'd1);

    // Reset while a read is in flight with three entries held.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
    wait_read();
    cycle(1'b0, 8'h00, 1'b0);
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("no_stale_pv", 32'(pop_valid), 32'd0);
      chk("no_stale_read", 32'(mem_read), 32'd0);
    end

    // Random traffic: a filling phase then a draining phase.
    for (int i = 0; i < 800; i++) begin
      if (i < 400) cycle($urandom_range(0, 99) < 80, 8'($urandom), $urandom_range(0, 99) < 30);
      else         cycle($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 99) < 80);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
